// File: rtl/timer_unit_pkg.sv
// Shared types and defaults for the timer unit: counter FSM states and default width.
package timer_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tcnt_state_e;

  localparam int TCNT_CNT_W_DEFAULT = 32;

endpackage : timer_unit_pkg

// File: rtl/timer_unit_tick_counter_if.sv
// Control/status bundle of the tick counter stage; the controller side drives
// the *_i members, the counter drives the *_o members.
interface timer_unit_tick_counter_if
  import timer_unit_pkg::*;
#(
  parameter int CNT_W = TCNT_CNT_W_DEFAULT
);

  logic             enable_count_i;
  logic             reset_count_i;
  logic             prescaler_en_i;
  logic             tick_i;
  logic             one_shot_i;
  logic             cmp_clr_i;
  logic [CNT_W-1:0] compare_value_i;
  logic             write_counter_i;
  logic [CNT_W-1:0] counter_value_i;
  logic [CNT_W-1:0] counter_value_o;
  logic             target_reached_o;
  logic             overflow_o;
  logic             irq_o;

  modport master (
    output enable_count_i, reset_count_i, prescaler_en_i, tick_i, one_shot_i,
           cmp_clr_i, compare_value_i, write_counter_i, counter_value_i,
    input  counter_value_o, target_reached_o, overflow_o, irq_o
  );

  modport slave (
    input  enable_count_i, reset_count_i, prescaler_en_i, tick_i, one_shot_i,
           cmp_clr_i, compare_value_i, write_counter_i, counter_value_i,
    output counter_value_o, target_reached_o, overflow_o, irq_o
  );

endinterface : timer_unit_tick_counter_if

// File: rtl/timer_unit_tick_counter.sv
// Main counter stage of the timer unit: advances on prescaler ticks (or every cycle),
// compares against a target and produces registered target/overflow pulses and an IRQ level.
module timer_unit_tick_counter
  import timer_unit_pkg::*;
#(
  parameter int CNT_W = TCNT_CNT_W_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  timer_unit_tick_counter_if.slave bus
);

  tcnt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             target_q, target_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;

  logic adv;
  logic match;
  logic clr;
  logic match_hold;

  assign adv        = bus.enable_count_i
                    & (bus.prescaler_en_i ? bus.tick_i : 1'b1)
                    & (state_q == RUN);
  assign match      = adv & (cnt_q == bus.compare_value_i);
  assign clr        = bus.reset_count_i | bus.write_counter_i;
  assign match_hold = match & bus.one_shot_i;

  // FSM next state; a clear/load in the match cycle keeps the counter in RUN.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.enable_count_i) state_d = RUN;
      RUN: begin
        if (!bus.enable_count_i)        state_d = IDLE;
        else if (match_hold && !clr)    state_d = DONE;
      end
      DONE: if (clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.reset_count_i)                  cnt_d = '0;
    else if (bus.write_counter_i)           cnt_d = bus.counter_value_i;
    else if (match_hold)                    cnt_d = cnt_q;
    else if (match && bus.cmp_clr_i)        cnt_d = '0;
    else if (adv)                           cnt_d = cnt_q + 1'b1;
  end

  // A wrap counts whenever the all-ones value advances, including a match-clear to zero.
  always_comb begin
    target_d = match & ~clr;
    ovf_d    = adv & (&cnt_q) & ~clr & ~match_hold;
    irq_d    = irq_q;
    if (clr)           irq_d = 1'b0;
    else if (target_d) irq_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.counter_value_o  = cnt_q;
  assign bus.target_reached_o = target_q;
  assign bus.overflow_o       = ovf_q;
  assign bus.irq_o            = irq_q;

endmodule : timer_unit_tick_counter
